// File: rtl/led_pwm_ctrl.sv
// Memory-mapped LED/GPIO controller: static or PWM drive per channel from a shared prescaled counter.
// Optional blink gate is compiled in with `define LED_PWM_CTRL_BLINK_EN.
module led_pwm_ctrl #(
  parameter int CHANNELS = 3,
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [3:0]          addr,
  input  logic [31:0]         d,
  input  logic [3:0]          we,
  output logic [31:0]         q,
  output logic [CHANNELS-1:0] out
);

  localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
  localparam logic [PWM_BITS-1:0] PWM_ONE = 1;

  logic                ctrl_en;
  logic [CHANNELS-1:0] outmask;
  logic [CHANNELS-1:0] mode;
  logic [15:0]         prescale;
  logic [PWM_BITS-1:0] duty [CHANNELS];
  logic [15:0]         pre_cnt;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic                phase;
  logic [CHANNELS-1:0] blink_ok;

  logic        wr;
  logic [31:0] wmask;
  logic [31:0] wdata;
  logic        pre_clr;
  logic        tick;
  logic        period_end;
  logic        unused_sig;

  assign wr    = en & (|we);
  assign wmask = {{8{we[3]}}, {8{we[2]}}, {8{we[1]}}, {8{we[0]}}};
  // q already holds the current value of the addressed register, so merging it
  // with the enabled lanes of d yields the post-write word for any index.
  assign wdata = (q & ~wmask) | (d & wmask);

  assign pre_clr    = wr && (addr == 4'd3) && (we[0] | we[1]);
  assign tick       = !pre_clr && (pre_cnt == prescale);
  assign period_end = tick && (pwm_cnt == PWM_MAX);
  assign unused_sig = ^{wdata, period_end};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_en  <= 1'b0;
      outmask  <= '0;
      mode     <= '0;
      prescale <= '0;
      for (int i = 0; i < CHANNELS; i++) duty[i] <= '0;
    end else if (wr) begin
      case (addr)
        4'd0:    ctrl_en  <= wdata[0];
        4'd1:    outmask  <= wdata[CHANNELS-1:0];
        4'd2:    mode     <= wdata[CHANNELS-1:0];
        4'd3:    prescale <= wdata[15:0];
        default: ;
      endcase
      for (int i = 0; i < CHANNELS; i++)
        if (addr == 4'(4 + i)) duty[i] <= wdata[PWM_BITS-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      pwm_cnt <= '0;
    end else begin
      pre_cnt <= (pre_clr || tick) ? 16'd0 : pre_cnt + 16'd1;
      if (tick) pwm_cnt <= pwm_cnt + PWM_ONE;
    end
  end

`ifdef LED_PWM_CTRL_BLINK_EN
  logic [15:0]         blink_half;
  logic [15:0]         blink_cnt;
  logic [CHANNELS-1:0] blink_mask;
  logic                blink_wr;

  assign blink_wr = wr && (addr == 4'd15);
  assign blink_ok = ~blink_mask | {CHANNELS{phase}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_half <= '0;
      blink_mask <= '0;
      blink_cnt  <= '0;
      phase      <= 1'b1;
    end else begin
      if (blink_wr) begin
        blink_half <= wdata[15:0];
        blink_mask <= wdata[16 +: CHANNELS];
      end
      // A zero half-period parks the gate open.
      if (blink_half == 16'd0) begin
        blink_cnt <= '0;
        phase     <= 1'b1;
      end else if (blink_wr) begin
        blink_cnt <= '0;
      end else if (period_end) begin
        if (blink_cnt >= blink_half - 16'd1) begin
          blink_cnt <= '0;
          phase     <= ~phase;
        end else begin
          blink_cnt <= blink_cnt + 16'd1;
        end
      end
    end
  end
`else
  assign phase    = 1'b1;
  assign blink_ok = '1;
`endif

  always_comb begin
    q = '0;
    case (addr)
      4'd0:  q[0] = ctrl_en;
      4'd1:  q[CHANNELS-1:0] = outmask;
      4'd2:  q[CHANNELS-1:0] = mode;
      4'd3:  q[15:0] = prescale;
      4'd14: begin
        q[PWM_BITS-1:0] = pwm_cnt;
        q[16]           = phase;
      end
`ifdef LED_PWM_CTRL_BLINK_EN
      4'd15: begin
        q[15:0]          = blink_half;
        q[16 +: CHANNELS] = blink_mask;
      end
`endif
      default: begin
        for (int i = 0; i < CHANNELS; i++)
          if (addr == 4'(4 + i)) q[PWM_BITS-1:0] = duty[i];
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        out[i] <= ctrl_en & outmask[i] & (mode[i] ? (pwm_cnt < duty[i]) : 1'b1) & blink_ok[i];
    end
  end

endmodule
